// File: rtl/coffee_pkg.sv
// Purpose: shared types and recipe table for the coffee machine dispense path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package coffee_pkg;

    localparam int DRINK_W = 3;

    typedef enum logic [DRINK_W-1:0] {
        ESPRESSO   = 3'd0,
        AMERICANO  = 3'd1,
        LATTE      = 3'd2,
        MOCHA      = 3'd3,
        CAPPUCCINO = 3'd4,
        HOT_CHOC   = 3'd5
    } drink_t;

    // Field order is also the dispense order: water first, sugar last.
    typedef struct packed {
        logic water;
        logic coffee;
        logic chocolate;
        logic milk;
        logic sugar;
    } ingredient_mask_t;

    typedef struct packed {
        logic             valid;
        ingredient_mask_t mask;
    } recipe_t;

    // Indexed by drink type; codes 6 and 7 are not drinks.
    //                                 valid  W C Ch M S
    localparam recipe_t [7:0] RECIPE = {6'b0_00000,   // 7 invalid
                                        6'b0_00000,   // 6 invalid
                                        6'b1_10110,   // 5 hot chocolate
                                        6'b1_01011,   // 4 cappuccino
                                        6'b1_01110,   // 3 mocha
                                        6'b1_01010,   // 2 latte
                                        6'b1_11000,   // 1 americano
                                        6'b1_11000};  // 0 espresso

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

endpackage

// File: rtl/dose_timer.sv
// Purpose: down-counter timing one valve dose; expire flags the final cycle of a dose.
// Latency: load takes effect on the next edge; expire is combinational from the count.
// Backpressure: none; enable freezes the count when low.
//
// Ports: clock, reset (sync, active-high), load/load_value (start a dose of
// load_value+1 cycles), enable (count while dispensing), expire (count is 0).
module dose_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/dispense_sequencer.sv
// Purpose: opens the ingredient valves one at a time, in fixed order, for a drink recipe.
// Latency: first valve one cycle after start; busy for sum(doses)+1 cycles, ending on a done pulse.
// Backpressure: none; start while busy is dropped, abort cancels a dispense without done.
//
// Ports: clock, reset (sync, active-high), start/drink_type (brew request),
// abort (cancel), busy, water/coffee/chocolate/milk/sugar (valves),
// done (completion pulse), error (invalid drink_type pulse). All outputs registered.
module dispense_sequencer
    import coffee_pkg::*;
#(
    parameter int WATER_CYCLES = 8,
    parameter int DOSE_CYCLES  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DRINK_W-1:0] drink_type,
    input  logic               abort,
    output logic               busy,
    output logic               water,
    output logic               coffee,
    output logic               chocolate,
    output logic               milk,
    output logic               sugar,
    output logic               done,
    output logic               error
);

    localparam int MAX_CYCLES = (WATER_CYCLES > DOSE_CYCLES) ? WATER_CYCLES : DOSE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    state_t           state_q, state_d;
    ingredient_mask_t valve_q, valve_d;
    ingredient_mask_t rem_q, rem_d;      // ingredients not yet dispensed
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             timer_load;
    logic [CW-1:0]    timer_value;
    logic             timer_expire;

    recipe_t          rec;
    ingredient_mask_t pick_start;
    ingredient_mask_t pick_next;

    // Highest-priority present ingredient, one-hot; zero when none remain.
    function automatic ingredient_mask_t first_of(input ingredient_mask_t m);
        ingredient_mask_t r;
        r = '0;
        if (m.water)          r.water     = 1'b1;
        else if (m.coffee)    r.coffee    = 1'b1;
        else if (m.chocolate) r.chocolate = 1'b1;
        else if (m.milk)      r.milk      = 1'b1;
        else if (m.sugar)     r.sugar     = 1'b1;
        return r;
    endfunction

    // Counter holds duration-1 so the phase ends when it reaches zero.
    function automatic logic [CW-1:0] dose_len(input logic is_water);
        return is_water ? CW'(WATER_CYCLES - 1) : CW'(DOSE_CYCLES - 1);
    endfunction

    assign rec        = RECIPE[drink_type];
    assign pick_start = first_of(rec.mask);
    assign pick_next  = first_of(rem_q);

    dose_timer #(
        .WIDTH (CW)
    ) u_dose_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (state_q == DISPENSE),
        .expire     (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        valve_d     = valve_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        timer_load  = 1'b0;
        timer_value = dose_len(pick_next.water);

        case (state_q)
            IDLE: begin
                valve_d = '0;
                busy_d  = 1'b0;
                if (start) begin
                    if (rec.valid) begin
                        valve_d     = pick_start;
                        rem_d       = ingredient_mask_t'(rec.mask & ~pick_start);
                        timer_load  = 1'b1;
                        timer_value = dose_len(pick_start.water);
                        busy_d      = 1'b1;
                        state_d     = DISPENSE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                if (abort) begin
                    valve_d = '0;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (timer_expire) begin
                    if (pick_next != '0) begin
                        // Back-to-back handover: next valve opens on the following cycle.
                        valve_d    = pick_next;
                        rem_d      = ingredient_mask_t'(rem_q & ~pick_next);
                        timer_load = 1'b1;
                    end else begin
                        valve_d = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valve_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valve_d = '0;
                rem_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            valve_q <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valve_q <= valve_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign busy      = busy_q;
    assign water     = valve_q.water;
    assign coffee    = valve_q.coffee;
    assign chocolate = valve_q.chocolate;
    assign milk      = valve_q.milk;
    assign sugar     = valve_q.sugar;
    assign done      = done_q;
    assign error     = error_q;

endmodule
